// File: rtl/delay_ctrl_pkg.sv
// Shared types and helpers for blocks that drive the delay line's delay_length.
package delay_ctrl_pkg;

  localparam int DLY_W = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    FILL = 3'd1,
    RUN  = 3'd2,
    SLEW = 3'd3,
    JUMP = 3'd4
  } delay_ctrl_state_t;

  // Saturate a requested delay into the legal [min_d, max_d] window.
  function automatic logic [DLY_W-1:0] clamp_delay(
    input logic [DLY_W-1:0] t,
    input logic [DLY_W-1:0] min_d,
    input logic [DLY_W-1:0] max_d
  );
    logic [DLY_W-1:0] r;
    r = t;
    if (t < min_d) r = min_d;
    else if (t > max_d) r = max_d;
    return r;
  endfunction

endpackage

// File: rtl/delay_line_controller.sv
// Sequencer for the negating audio delay line: owns enable/delay_length and
// the mute gate so start-up and delay changes never produce audible clicks.
module delay_line_controller
  import delay_ctrl_pkg::*;
#(
  parameter int unsigned MEMORY_SIZE   = 1000,
  parameter int unsigned DEFAULT_DELAY = 100,
  parameter int unsigned MIN_DELAY     = 1,
  parameter int unsigned SLEW_STEP     = 1,
  parameter int unsigned JUMP_THRESH   = 64,
  parameter int unsigned MUTE_SAMPLES  = 32,
  parameter int unsigned FILL_MARGIN   = 2
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             enable_in,
  input  logic             audio_valid_in,
  input  logic [DLY_W-1:0] target_delay_in,
  input  logic             target_valid_in,
  output logic             target_ready_out,
  output logic             enable_delay_out,
  output logic [DLY_W-1:0] delay_length_out,
  output logic             mute_out,
  output logic             busy_out
);

  localparam logic [DLY_W-1:0] MIN_D  = DLY_W'(MIN_DELAY);
  localparam logic [DLY_W-1:0] MAX_D  = DLY_W'(MEMORY_SIZE - 1);
  localparam logic [DLY_W-1:0] DEF_D  = DLY_W'(DEFAULT_DELAY);
  localparam logic [DLY_W-1:0] STEP   = DLY_W'(SLEW_STEP);
  localparam logic [DLY_W:0]   JTH    = (DLY_W+1)'(JUMP_THRESH);
  localparam logic [DLY_W:0]   MUTE_N = (DLY_W+1)'(MUTE_SAMPLES);
  localparam logic [DLY_W:0]   MARGIN = (DLY_W+1)'(FILL_MARGIN);

  delay_ctrl_state_t state_q, state_d;
  logic [DLY_W-1:0]  delay_q, delay_d;
  logic [DLY_W-1:0]  target_q, target_d;
  logic [DLY_W-1:0]  cnt_q, cnt_d;
  logic              enable_q, enable_d;
  logic              mute_q, mute_d;
  logic              busy_q, busy_d;

  logic              accept;
  logic [DLY_W-1:0]  tgt_clamped;
  logic signed [DLY_W:0] diff;
  logic [DLY_W:0]    abs_diff;
  logic              slew_up;
  logic [DLY_W-1:0]  slew_gap;
  logic [DLY_W:0]    cnt_inc;
  logic [DLY_W:0]    fill_end;

  // Targets are only taken while the delay is settled (or the line is off).
  assign target_ready_out = (state_q == IDLE) || (state_q == RUN);
  assign accept           = target_valid_in && target_ready_out;

  // Distance math is 17-bit so the sign and the fill end point never wrap.
  always_comb begin
    tgt_clamped = clamp_delay(target_delay_in, MIN_D, MAX_D);
    diff        = $signed({1'b0, tgt_clamped}) - $signed({1'b0, delay_q});
    abs_diff    = diff[DLY_W] ? 17'(-diff) : 17'(diff);
    slew_up     = target_q > delay_q;
    slew_gap    = slew_up ? (target_q - delay_q) : (delay_q - target_q);
    cnt_inc     = {1'b0, cnt_q} + 17'd1;
    fill_end    = {1'b0, delay_q} + MARGIN;
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d  = state_q;
    delay_d  = delay_q;
    target_d = target_q;
    cnt_d    = cnt_q;

    if (!enable_in) begin
      // Drop out from anywhere; an in-flight slew/jump is abandoned where it is.
      state_d = IDLE;
      cnt_d   = '0;
      if (accept) begin
        delay_d  = tgt_clamped;
        target_d = tgt_clamped;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            delay_d  = tgt_clamped;
            target_d = tgt_clamped;
          end
          state_d = FILL;
          cnt_d   = '0;
        end
        FILL: begin
          if (audio_valid_in) begin
            cnt_d = cnt_inc[DLY_W-1:0];
            if (cnt_inc == fill_end) begin
              state_d = RUN;
              cnt_d   = '0;
            end
          end
        end
        RUN: begin
          if (accept) begin
            target_d = tgt_clamped;
            if (abs_diff == '0) begin
              state_d = RUN;
            end else if (abs_diff <= JTH) begin
              state_d = SLEW;
            end else begin
              state_d = JUMP;
              delay_d = tgt_clamped;
              cnt_d   = '0;
            end
          end
        end
        SLEW: begin
          if (audio_valid_in) begin
            if (slew_gap <= STEP) begin
              delay_d = target_q;
              state_d = RUN;
            end else begin
              delay_d = slew_up ? (delay_q + STEP) : (delay_q - STEP);
            end
          end
        end
        JUMP: begin
          if (audio_valid_in) begin
            cnt_d = cnt_inc[DLY_W-1:0];
            if (cnt_inc == MUTE_N) begin
              state_d = RUN;
              cnt_d   = '0;
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // Outputs follow the state being entered, so they change on the same edge.
    enable_d = (state_d != IDLE);
    mute_d   = (state_d == IDLE) || (state_d == FILL) || (state_d == JUMP);
    busy_d   = (state_d == FILL) || (state_d == SLEW) || (state_d == JUMP);
  end

  // State, counter and output registers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q  <= IDLE;
      delay_q  <= DEF_D;
      target_q <= DEF_D;
      cnt_q    <= '0;
      enable_q <= 1'b0;
      mute_q   <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      delay_q  <= delay_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      enable_q <= enable_d;
      mute_q   <= mute_d;
      busy_q   <= busy_d;
    end
  end

  assign enable_delay_out = enable_q;
  assign delay_length_out = delay_q;
  assign mute_out         = mute_q;
  assign busy_out         = busy_q;

endmodule
